// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Round-robin arbiter that shares the register file's single write port
// between ALU writeback (requester 0) and load writeback (requester 1).
// Grants are combinational; the write port toward the register file is
// registered, so an accepted request shows up on write_reg/write_data/
// reg_write one cycle later. Writes to register 0 can be consumed
// silently, and saturating per-requester grant counters are kept for debug.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 5,
  parameter int unsigned CNT_WIDTH        = 16,
  parameter bit          ZERO_REG_PROTECT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_0,
  input  logic [ADDR_WIDTH-1:0] wr_reg_0,
  input  logic [DATA_WIDTH-1:0] wr_data_0,
  output logic                  gnt_0,
  input  logic                  req_1,
  input  logic [ADDR_WIDTH-1:0] wr_reg_1,
  input  logic [DATA_WIDTH-1:0] wr_data_1,
  output logic                  gnt_1,
  output logic [ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  reg_write,
  output logic [CNT_WIDTH-1:0]  grant_count_0,
  output logic [CNT_WIDTH-1:0]  grant_count_1
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_e;

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = {ADDR_WIDTH{1'b0}};

  wr_state_e             state_q, state_d;
  logic                  prio_q, prio_d;
  logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [CNT_WIDTH-1:0]  cnt_0_q, cnt_0_d;
  logic [CNT_WIDTH-1:0]  cnt_1_q, cnt_1_d;

  logic                  gnt_0_s, gnt_1_s;
  logic                  any_gnt_s;
  logic                  issue_s;
  logic [ADDR_WIDTH-1:0] sel_reg_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  reg_write_s;

  // Saturating increment used by both grant counters.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    if (cnt == CNT_MAX) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + CNT_ONE;
    end
  endfunction

  // Round-robin grant; both grants are held low while reset is asserted.
  always_comb begin
    gnt_0_s = 1'b0;
    gnt_1_s = 1'b0;
    if (!reset) begin
      gnt_0_s = 1'b0;
      gnt_1_s = 1'b0;
    end else if (req_0 && req_1) begin
      gnt_0_s = ~prio_q;
      gnt_1_s = prio_q;
    end else if (req_0) begin
      gnt_0_s = 1'b1;
    end else if (req_1) begin
      gnt_1_s = 1'b1;
    end else begin
      gnt_0_s = 1'b0;
      gnt_1_s = 1'b0;
    end
  end

  assign gnt_0     = gnt_0_s;
  assign gnt_1     = gnt_1_s;
  assign any_gnt_s = gnt_0_s | gnt_1_s;

  // Select the winner's payload and decide whether it reaches the register file.
  always_comb begin
    sel_reg_s  = wr_reg_0;
    sel_data_s = wr_data_0;
    if (gnt_1_s) begin
      sel_reg_s  = wr_reg_1;
      sel_data_s = wr_data_1;
    end else begin
      sel_reg_s  = wr_reg_0;
      sel_data_s = wr_data_0;
    end
    issue_s = any_gnt_s && ((sel_reg_s != REG_ZERO) || !ZERO_REG_PROTECT);
  end

  // Next values for the write-port payload, priority pointer and counters.
  always_comb begin
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    prio_d       = prio_q;
    cnt_0_d      = cnt_0_q;
    cnt_1_d      = cnt_1_q;
    if (issue_s) begin
      write_reg_d  = sel_reg_s;
      write_data_d = sel_data_s;
    end else begin
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
    end
    if (gnt_0_s) begin
      prio_d  = 1'b1;
      cnt_0_d = sat_inc(cnt_0_q);
    end else if (gnt_1_s) begin
      prio_d  = 1'b0;
      cnt_1_d = sat_inc(cnt_1_q);
    end else begin
      prio_d = prio_q;
    end
  end

  // Write-port FSM next state: WRITE for exactly the cycle after an issued grant.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = issue_s ? ST_WRITE : ST_IDLE;
      ST_WRITE: state_d = issue_s ? ST_WRITE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write-port FSM output decode.
  always_comb begin
    reg_write_s = 1'b0;
    case (state_q)
      ST_IDLE:  reg_write_s = 1'b0;
      ST_WRITE: reg_write_s = 1'b1;
      default:  reg_write_s = 1'b0;
    endcase
  end

  // State registers; reset drops any in-flight write immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      write_reg_q  <= {ADDR_WIDTH{1'b0}};
      write_data_q <= {DATA_WIDTH{1'b0}};
      cnt_0_q      <= {CNT_WIDTH{1'b0}};
      cnt_1_q      <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      cnt_0_q      <= cnt_0_d;
      cnt_1_q      <= cnt_1_d;
    end
  end

  assign reg_write     = reg_write_s;
  assign write_reg     = write_reg_q;
  assign write_data    = write_data_q;
  assign grant_count_0 = cnt_0_q;
  assign grant_count_1 = cnt_1_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter. Three instances share one
// stimulus stream: default parameters, ZERO_REG_PROTECT=0, and CNT_WIDTH=4.
// Expected grants are checked combinationally when stimulus is driven; the
// expected post-edge write port and counters are queued and compared after
// the edge.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_0 = 1'b0, req_1 = 1'b0;
  logic [4:0]  wr_reg_0 = 5'd0, wr_reg_1 = 5'd0;
  logic [31:0] wr_data_0 = 32'd0, wr_data_1 = 32'd0;

  logic        gnt0_m, gnt1_m, rw_m;
  logic [4:0]  wreg_m;
  logic [31:0] wdata_m;
  logic [15:0] gc0_m, gc1_m;

  logic        gnt0_n, gnt1_n, rw_n;
  logic [4:0]  wreg_n;
  logic [31:0] wdata_n;
  logic [15:0] gc0_n, gc1_n;

  logic        gnt0_s, gnt1_s, rw_s;
  logic [4:0]  wreg_s;
  logic [31:0] wdata_s;
  logic [3:0]  gc0_s, gc1_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        rw_nz;
    logic [4:0]  wreg_nz;
    logic [31:0] wdata_nz;
    logic [15:0] c0;
    logic [15:0] c1;
    logic [3:0]  sc0;
    logic [3:0]  sc1;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic        m_prio;
  logic [4:0]  m_reg, m_reg_nz;
  logic [31:0] m_data, m_data_nz;
  logic [15:0] m_c0, m_c1;
  logic [3:0]  m_sc0, m_sc1;

  always #5 clk = ~clk;

  regfile_write_arbiter u_dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .wr_reg_0(wr_reg_0), .wr_data_0(wr_data_0), .gnt_0(gnt0_m),
    .req_1(req_1), .wr_reg_1(wr_reg_1), .wr_data_1(wr_data_1), .gnt_1(gnt1_m),
    .write_reg(wreg_m), .write_data(wdata_m), .reg_write(rw_m),
    .grant_count_0(gc0_m), .grant_count_1(gc1_m)
  );

  regfile_write_arbiter #(.ZERO_REG_PROTECT(1'b0)) u_dut_nz (
    .clk(clk), .reset(reset),
    .req_0(req_0), .wr_reg_0(wr_reg_0), .wr_data_0(wr_data_0), .gnt_0(gnt0_n),
    .req_1(req_1), .wr_reg_1(wr_reg_1), .wr_data_1(wr_data_1), .gnt_1(gnt1_n),
    .write_reg(wreg_n), .write_data(wdata_n), .reg_write(rw_n),
    .grant_count_0(gc0_n), .grant_count_1(gc1_n)
  );

  regfile_write_arbiter #(.CNT_WIDTH(4)) u_dut_sat (
    .clk(clk), .reset(reset),
    .req_0(req_0), .wr_reg_0(wr_reg_0), .wr_data_0(wr_data_0), .gnt_0(gnt0_s),
    .req_1(req_1), .wr_reg_1(wr_reg_1), .wr_data_1(wr_data_1), .gnt_1(gnt1_s),
    .write_reg(wreg_s), .write_data(wdata_s), .reg_write(rw_s),
    .grant_count_0(gc0_s), .grant_count_1(gc1_s)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prio    = 1'b0;
    m_reg     = 5'd0;
    m_data    = 32'd0;
    m_reg_nz  = 5'd0;
    m_data_nz = 32'd0;
    m_c0      = 16'd0;
    m_c1      = 16'd0;
    m_sc0     = 4'd0;
    m_sc1     = 4'd0;
    sb_q.delete();
  endtask

  // Assert reset asynchronously (mid-cycle), check cleared state, release at a negedge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_val("rst_reg_write",   64'(rw_m),    64'(1'b0));
    check_val("rst_reg_write_nz",64'(rw_n),    64'(1'b0));
    check_val("rst_write_reg",   64'(wreg_m),  64'(5'd0));
    check_val("rst_write_data",  64'(wdata_m), 64'(32'd0));
    check_val("rst_cnt0",        64'(gc0_m),   64'(16'd0));
    check_val("rst_cnt1",        64'(gc1_m),   64'(16'd0));
    check_val("rst_sat_cnt0",    64'(gc0_s),   64'(4'd0));
    check_val("rst_gnt0",        64'(gnt0_m),  64'(1'b0));
    check_val("rst_gnt1",        64'(gnt1_m),  64'(1'b0));
    req_0 = 1'b0;
    req_1 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One cycle: drive at negedge, check grants, queue expectation, compare after edge.
  task automatic step(input logic r0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic r1, input logic [4:0] a1, input logic [31:0] d1,
                      output logic g0, output logic g1);
    exp_t e;
    exp_t got;
    logic [4:0]  sreg;
    logic [31:0] sdata;
    @(negedge clk);
    req_0 = r0; wr_reg_0 = a0; wr_data_0 = d0;
    req_1 = r1; wr_reg_1 = a1; wr_data_1 = d1;
    #1;
    g0 = r0 && (!r1 || (m_prio == 1'b0));
    g1 = r1 && !g0;
    check_val("gnt_0",     64'(gnt0_m), 64'(g0));
    check_val("gnt_1",     64'(gnt1_m), 64'(g1));
    check_val("gnt_excl",  64'(gnt0_m & gnt1_m), 64'(1'b0));
    e.rw = 1'b0;
    e.rw_nz = 1'b0;
    if (g0 || g1) begin
      sreg  = g0 ? a0 : a1;
      sdata = g0 ? d0 : d1;
      if (sreg != 5'd0) begin
        m_reg  = sreg;
        m_data = sdata;
        e.rw   = 1'b1;
      end
      m_reg_nz  = sreg;
      m_data_nz = sdata;
      e.rw_nz   = 1'b1;
      m_prio    = g0 ? 1'b1 : 1'b0;
    end
    if (g0) begin
      if (m_c0 != 16'hFFFF) m_c0 = m_c0 + 16'd1;
      if (m_sc0 != 4'hF)    m_sc0 = m_sc0 + 4'd1;
    end
    if (g1) begin
      if (m_c1 != 16'hFFFF) m_c1 = m_c1 + 16'd1;
      if (m_sc1 != 4'hF)    m_sc1 = m_sc1 + 4'd1;
    end
    e.wreg = m_reg;       e.wdata = m_data;
    e.wreg_nz = m_reg_nz; e.wdata_nz = m_data_nz;
    e.c0 = m_c0; e.c1 = m_c1; e.sc0 = m_sc0; e.sc1 = m_sc1;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    check_val("sb_depth", 64'(sb_q.size()), 64'(1));
    if (sb_q.size() != 0) begin
      got = sb_q.pop_front();
      check_val("reg_write",     64'(rw_m),    64'(got.rw));
      check_val("write_reg",     64'(wreg_m),  64'(got.wreg));
      check_val("write_data",    64'(wdata_m), 64'(got.wdata));
      check_val("cnt0",          64'(gc0_m),   64'(got.c0));
      check_val("cnt1",          64'(gc1_m),   64'(got.c1));
      check_val("nz_reg_write",  64'(rw_n),    64'(got.rw_nz));
      check_val("nz_write_reg",  64'(wreg_n),  64'(got.wreg_nz));
      check_val("nz_write_data", 64'(wdata_n), 64'(got.wdata_nz));
      check_val("nz_cnt0",       64'(gc0_n),   64'(got.c0));
      check_val("nz_cnt1",       64'(gc1_n),   64'(got.c1));
      check_val("sat_reg_write", 64'(rw_s),    64'(got.rw));
      check_val("sat_write_reg", 64'(wreg_s),  64'(got.wreg));
      check_val("sat_write_data",64'(wdata_s), 64'(got.wdata));
      check_val("sat_cnt0",      64'(gc0_s),   64'(got.sc0));
      check_val("sat_cnt1",      64'(gc1_s),   64'(got.sc1));
      check_val("nz_gnt",        64'({gnt0_n, gnt1_n}), 64'({gnt0_m, gnt1_m}));
      check_val("sat_gnt",       64'({gnt0_s, gnt1_s}), 64'({gnt0_m, gnt1_m}));
    end
  endtask

  initial begin : main
    logic g0, g1;
    logic p0, p1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;

    // Requests high during reset: grants must stay forced low.
    req_0 = 1'b1;
    req_1 = 1'b1;
    #2;
    do_reset();

    // Single requester
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, g0, g1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g0, g1);

    // Contention from reset: 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, g0, g1);
    end
    check_val("contention_cnt0", 64'(gc0_m), 64'(16'd2));
    check_val("contention_cnt1", 64'(gc1_m), 64'(16'd2));
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g0, g1);

    // Zero register from requester 1
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, g0, g1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g0, g1);

    // Idle after a write to reg 7; prio must survive the idle stretch
    step(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, g0, g1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g0, g1);
    end
    step(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99, g0, g1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, g0, g1);

    // Saturation of the 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 5'd3, 32'(i), 1'b0, 5'd0, 32'd0, g0, g1);
    end
    check_val("sat_cnt0_final", 64'(gc0_s), 64'(4'hF));

    // Reset while a write is on the port, then both request after release
    step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, g0, g1);
    req_0 = 1'b1;
    do_reset();
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, g0, g1);
    check_val("post_reset_first_gnt", 64'(g0), 64'(1'b1));

    // Random traffic honouring the hold-until-granted rule
    p0 = 1'b0; p1 = 1'b1;
    a0 = 5'd0; a1 = 5'd6; d0 = 32'd0; d1 = 32'h66;
    for (int i = 0; i < 40; i++) begin
      if (!p0) begin
        p0 = 1'($urandom_range(0, 1));
        a0 = 5'($urandom_range(0, 31));
        d0 = $urandom;
      end
      if (!p1) begin
        p1 = 1'($urandom_range(0, 1));
        a1 = 5'($urandom_range(0, 31));
        d1 = $urandom;
      end
      step(p0, a0, d0, p1, a1, d1, g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g0, g1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
